fic2_apb_csr_slave: RTL

//  APB3 completer on the MSS FIC_2_APB_M master port. Gives Cortex-M3 firmware a fabric CSR block:
//  ID, scratch, control, sticky event status with IRQ, and a 32-bit free-running counter.

---
 rtl/fic2_apb_csr_pkg.sv | 43 ++++
 rtl/fic2_apb_csr_if.sv | 31 +++
 rtl/fic2_apb_wait_ctrl.sv | 88 ++++++++
 rtl/fic2_apb_csr_slave.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fic2_apb_csr_pkg.sv
// ----------------------------------------------------------------------------
// fic2_apb_csr_pkg
//   Shared definitions for the FIC_2 APB CSR completer:
//   - register word offsets (PADDR[4:2]); byte offset = word offset * 4
//   - CTRL / STATUS bit positions
//   - wait-state FSM state type and encodings
//   - address legality helper
// ----------------------------------------------------------------------------
package fic2_apb_csr_pkg;

    localparam int ADDR_W = 14;   // PADDR carries the word address [15:2]
    localparam int DATA_W = 32;

    // Word offsets of the mapped registers
    localparam logic [2:0] OFS_ID      = 3'd0;  // 0x00
    localparam logic [2:0] OFS_SCRATCH = 3'd1;  // 0x04
    localparam logic [2:0] OFS_CTRL    = 3'd2;  // 0x08
    localparam logic [2:0] OFS_STATUS  = 3'd3;  // 0x0C
    localparam logic [2:0] OFS_COUNT   = 3'd4;  // 0x10

    // CTRL fields
    localparam int CTRL_CNT_EN  = 0;
    localparam int CTRL_CNT_CLR = 1;
    localparam int CTRL_MASK_LO = 8;
    localparam int CTRL_MASK_HI = 16;

    // STATUS fields: [7:0] sticky events, [8] counter overflow
    localparam int STATUS_OVF = 8;
    localparam int STATUS_W   = 9;

    // Wait-state FSM
    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_WAIT = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // An address is legal only when the undecoded upper bits are zero and the
    // decoded offset hits one of the five registers.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] paddr);
        return (paddr[ADDR_W-1:3] == '0) && (paddr[2:0] <= OFS_COUNT);
    endfunction

endpackage

// File: rtl/fic2_apb_csr_if.sv
// ----------------------------------------------------------------------------
// fic2_apb_csr_if
//   APB3 bus bundle between the MSS FIC_2_APB_M master and the fabric CSR
//   completer.
//   master modport: drives psel/penable/pwrite/paddr/pwdata,
//                   receives prdata/pready/pslverr
//   slave  modport: the mirror image
// ----------------------------------------------------------------------------
interface fic2_apb_csr_if;
    import fic2_apb_csr_pkg::*;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/fic2_apb_wait_ctrl.sv
// ----------------------------------------------------------------------------
// fic2_apb_wait_ctrl
//   IDLE/WAIT/DONE sequencer that stretches each APB access by WAIT_STATES
//   cycles of PREADY=0.
//   Ports:
//     i_clk      clock (PCLK)
//     i_rst      synchronous active-high reset
//     i_psel     APB select
//     i_penable  APB access phase
//     o_pready   registered completion, high for exactly the DONE cycle
//     o_capture  high in the cycle whose closing edge enters DONE; the top
//                latches PRDATA/PSLVERR on that edge
//     o_commit   high during DONE; a write takes effect on the closing edge
// ----------------------------------------------------------------------------
module fic2_apb_wait_ctrl
    import fic2_apb_csr_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_psel,
    input  logic i_penable,
    output logic o_pready,
    output logic o_capture,
    output logic o_commit
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    fsm_state_t r_state;
    fsm_state_t w_state_nxt;
    logic [3:0] r_wcnt;
    logic [3:0] w_wcnt_nxt;
    logic       r_pready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a value unassigned and infer a latch.
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            ST_IDLE: begin
                if (i_psel && !i_penable) begin
                    w_wcnt_nxt  = WS;
                    w_state_nxt = (WS == 4'd0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_psel) begin
                    // Master abandoned the transfer: nothing commits.
                    w_state_nxt = ST_IDLE;
                end else if (r_wcnt == 4'd1) begin
                    w_state_nxt = ST_DONE;
                    w_wcnt_nxt  = 4'd0;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            ST_DONE: begin
                // Always one DONE cycle; a new setup may arrive right after.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_wcnt   <= 4'd0;
            r_pready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_pready <= (w_state_nxt == ST_DONE);
        end
    end

    assign o_pready  = r_pready;
    assign o_capture = (w_state_nxt == ST_DONE);
    assign o_commit  = (r_state == ST_DONE);

endmodule

// File: rtl/fic2_apb_csr_slave.sv
// ----------------------------------------------------------------------------
// fic2_apb_csr_slave
//   APB3 completer on FIC_2_APB_M giving firmware a small CSR block:
//     0x00 ID      RO   ID_VALUE
//     0x04 SCRATCH RW
//     0x08 CTRL    RW   [0] CNT_EN, [1] CNT_CLR (write-1 pulse), [16:8] IRQ_MASK
//     0x0C STATUS  W1C  [7:0] sticky EVENT_IN, [8] counter overflow
//     0x10 COUNT   RO   free-running 32-bit counter
//   Unmapped offsets (or nonzero PADDR[15:5]) answer PSLVERR=1, PRDATA=0.
//   Ports:
//     i_pclk      sole clock
//     i_preset    synchronous active-high reset
//     io_apb      APB3 slave bundle (psel/penable/pwrite/paddr/pwdata in,
//                 prdata/pready/pslverr out, all outputs registered)
//     i_event_in  single-cycle fabric event pulses
//     o_irq       registered level interrupt
// ----------------------------------------------------------------------------
module fic2_apb_csr_slave
    import fic2_apb_csr_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5453_4135
) (
    input  logic                 i_pclk,
    input  logic                 i_preset,
    fic2_apb_csr_if.slave        io_apb,
    input  logic [7:0]           i_event_in,
    output logic                 o_irq
);

    // ------------------------------------------------------------------
    // Transfer sequencing
    // ------------------------------------------------------------------
    logic w_pready;
    logic w_capture;
    logic w_commit;

    fic2_apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .i_clk     (i_pclk),
        .i_rst     (i_preset),
        .i_psel    (io_apb.psel),
        .i_penable (io_apb.penable),
        .o_pready  (w_pready),
        .o_capture (w_capture),
        .o_commit  (w_commit)
    );

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_addr_ok;
    logic [2:0] w_ofs;
    logic       w_wr;
    logic       w_wr_scratch;
    logic       w_wr_ctrl;
    logic       w_wr_status;
    logic       w_cnt_clr;

    assign w_addr_ok    = addr_valid(io_apb.paddr);
    assign w_ofs        = io_apb.paddr[2:0];
    assign w_wr         = w_commit && io_apb.pwrite && w_addr_ok;
    assign w_wr_scratch = w_wr && (w_ofs == OFS_SCRATCH);
    assign w_wr_ctrl    = w_wr && (w_ofs == OFS_CTRL);
    assign w_wr_status  = w_wr && (w_ofs == OFS_STATUS);
    assign w_cnt_clr    = w_wr_ctrl && io_apb.pwdata[CTRL_CNT_CLR];

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic [31:0]         r_scratch;
    logic                r_cnt_en;
    logic [8:0]          r_irq_mask;
    logic [STATUS_W-1:0] r_status;
    logic [31:0]         r_count;
    logic                r_irq;
    logic [31:0]         r_prdata;
    logic                r_pslverr;

    // Read mux; CNT_CLR and reserved CTRL bits read back as zero.
    logic [31:0] w_rdata;
    always_comb begin
        w_rdata = '0;
        if (w_addr_ok) begin
            case (w_ofs)
                OFS_ID:      w_rdata = ID_VALUE;
                OFS_SCRATCH: w_rdata = r_scratch;
                OFS_CTRL: begin
                    w_rdata[CTRL_CNT_EN]                = r_cnt_en;
                    w_rdata[CTRL_MASK_HI:CTRL_MASK_LO] = r_irq_mask;
                end
                OFS_STATUS:  w_rdata[STATUS_W-1:0] = r_status;
                OFS_COUNT:   w_rdata = r_count;
                default:     w_rdata = '0;
            endcase
        end
    end

    // A clear in the same cycle pre-empts both the increment and the wrap.
    logic                w_count_wrap;
    logic [STATUS_W-1:0] w_w1c;

    assign w_count_wrap = r_cnt_en && !w_cnt_clr && (r_count == 32'hFFFF_FFFF);
    assign w_w1c        = w_wr_status ? io_apb.pwdata[STATUS_W-1:0] : '0;

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            r_scratch  <= '0;
            r_cnt_en   <= 1'b0;
            r_irq_mask <= '0;
            r_status   <= '0;
            r_count    <= '0;
            r_irq      <= 1'b0;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
        end else begin
            // Response is latched on entry to DONE; writes return zero data.
            if (w_capture) begin
                r_prdata  <= io_apb.pwrite ? 32'd0 : w_rdata;
                r_pslverr <= !w_addr_ok;
            end

            if (w_wr_scratch) begin
                r_scratch <= io_apb.pwdata;
            end

            if (w_wr_ctrl) begin
                r_cnt_en   <= io_apb.pwdata[CTRL_CNT_EN];
                r_irq_mask <= io_apb.pwdata[CTRL_MASK_HI:CTRL_MASK_LO];
            end

            if (w_cnt_clr) begin
                r_count <= '0;
            end else if (r_cnt_en) begin
                r_count <= r_count + 32'd1;
            end

            // Clear first, then OR in new sets so a same-cycle set survives.
            r_status <= (r_status & ~w_w1c) | {w_count_wrap, i_event_in};

            r_irq <= |(r_status & r_irq_mask);
        end
    end

    assign io_apb.prdata  = r_prdata;
    assign io_apb.pready  = w_pready;
    assign io_apb.pslverr = r_pslverr;
    assign o_irq          = r_irq;

endmodule
